// File: rtl/mem_access_unit.sv
// Memory stage access unit: word-aligned load/store bus master with
// misalignment detection, request timeout and MEM/WB passthroughs.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ExMe_out_alu_out,
    input  logic [31:0] ExMe_out_reg_2,
    input  logic        ExMe_out_mem_en,
    input  logic        ExMe_out_mem_wrt,
    input  logic        ExMe_out_reg_wrt_en,
    input  logic [1:0]  ExMe_out_result_sel,
    input  logic [31:0] ExMe_out_PC_next,
    input  logic [31:0] ExMe_out_LR,
    input  logic [1:0]  ExMe_out_FL,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        stall_mem,
    output logic [31:0] MeWb_in_mem_data,
    output logic [31:0] MeWb_in_alu_out,
    output logic        MeWb_in_reg_wrt_en,
    output logic [1:0]  MeWb_in_result_sel,
    output logic [31:0] MeWb_in_PC_next,
    output logic [31:0] MeWb_in_LR,
    output logic [1:0]  MeWb_in_FL,
    output logic        mem_err_misalign,
    output logic        mem_err_timeout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rbuf;
    logic        r_we;
    logic [15:0] r_cnt;

    logic        w_aligned;
    logic        w_busy;
    logic        w_timeout;
    logic [31:0] w_word_addr;

    assign w_aligned   = (ExMe_out_alu_out[1:0] == 2'b00);
    assign w_word_addr = {ExMe_out_alu_out[31:2], 2'b00};
    assign w_busy      = (r_state == S_REQ) || (r_state == S_WAIT);
    assign w_timeout   = w_busy && (r_cnt == 16'(TIMEOUT_CYCLES));

    assign MeWb_in_alu_out    = ExMe_out_alu_out;
    assign MeWb_in_reg_wrt_en = ExMe_out_reg_wrt_en;
    assign MeWb_in_result_sel = ExMe_out_result_sel;
    assign MeWb_in_PC_next    = ExMe_out_PC_next;
    assign MeWb_in_LR         = ExMe_out_LR;
    assign MeWb_in_FL         = ExMe_out_FL;

    assign mem_we    = r_we && (r_state == S_REQ);
    assign mem_wdata = r_wdata;

    always_comb begin
        w_next           = r_state;
        mem_req          = 1'b0;
        stall_mem        = 1'b0;
        mem_err_misalign = 1'b0;
        mem_err_timeout  = 1'b0;
        MeWb_in_mem_data = 32'h0;
        mem_addr         = r_addr;
        unique case (r_state)
            S_IDLE: begin
                if (ExMe_out_mem_en) begin
                    if (w_aligned) begin
                        stall_mem = 1'b1;
                        w_next    = S_REQ;
                    end else begin
                        mem_err_misalign = 1'b1;
                    end
                end
            end
            S_REQ: begin
                mem_req   = 1'b1;
                stall_mem = 1'b1;
                if (w_timeout) begin
                    mem_err_timeout = 1'b1;
                    w_next          = S_DONE;
                end else if (mem_gnt) begin
                    w_next = r_we ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                stall_mem = 1'b1;
                if (w_timeout) begin
                    mem_err_timeout = 1'b1;
                    w_next          = S_DONE;
                end else if (mem_rvalid) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                MeWb_in_mem_data = r_rbuf;
                mem_addr         = w_word_addr;
                w_next           = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_we    <= 1'b0;
            r_cnt   <= 16'h0;
            r_rbuf  <= 32'h0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_next == S_REQ) begin
                // Bus fields are frozen here so they stay stable through REQ.
                r_addr  <= w_word_addr;
                r_we    <= ExMe_out_mem_wrt;
                r_wdata <= ExMe_out_reg_2;
                r_cnt   <= 16'h0;
                r_rbuf  <= 32'h0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + 16'h1;
                if (w_timeout) begin
                    r_rbuf <= 32'h0;
                end else if (r_state == S_WAIT && mem_rvalid) begin
                    r_rbuf <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES=8).
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_out;
    logic [31:0] reg_2;
    logic        mem_en;
    logic        mem_wrt;
    logic        reg_wrt_en;
    logic [1:0]  result_sel;
    logic [31:0] pc_next;
    logic [31:0] lr;
    logic [1:0]  fl;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall_mem;
    logic [31:0] wb_mem_data;
    logic [31:0] wb_alu_out;
    logic        wb_reg_wrt_en;
    logic [1:0]  wb_result_sel;
    logic [31:0] wb_pc_next;
    logic [31:0] wb_lr;
    logic [1:0]  wb_fl;
    logic        err_mis;
    logic        err_to;

    int errors = 0;
    int checks = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ExMe_out_alu_out    (alu_out),
        .ExMe_out_reg_2      (reg_2),
        .ExMe_out_mem_en     (mem_en),
        .ExMe_out_mem_wrt    (mem_wrt),
        .ExMe_out_reg_wrt_en (reg_wrt_en),
        .ExMe_out_result_sel (result_sel),
        .ExMe_out_PC_next    (pc_next),
        .ExMe_out_LR         (lr),
        .ExMe_out_FL         (fl),
        .mem_req             (mem_req),
        .mem_we              (mem_we),
        .mem_addr            (mem_addr),
        .mem_wdata           (mem_wdata),
        .mem_gnt             (mem_gnt),
        .mem_rvalid          (mem_rvalid),
        .mem_rdata           (mem_rdata),
        .stall_mem           (stall_mem),
        .MeWb_in_mem_data    (wb_mem_data),
        .MeWb_in_alu_out     (wb_alu_out),
        .MeWb_in_reg_wrt_en  (wb_reg_wrt_en),
        .MeWb_in_result_sel  (wb_result_sel),
        .MeWb_in_PC_next     (wb_pc_next),
        .MeWb_in_LR          (wb_lr),
        .MeWb_in_FL          (wb_fl),
        .mem_err_misalign    (err_mis),
        .mem_err_timeout     (err_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge so inputs can be driven.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        alu_out = 32'h0000_0104;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || stall_mem !== 1'b0 ||
            err_mis !== 1'b0 || err_to !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req=%b stall=%b mis=%b to=%b want 0000",
                     mem_req, stall_mem, err_mis, err_to);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || wb_mem_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h data=%h want 0",
                     mem_addr, mem_wdata, wb_mem_data);
        end
        next_cycle();
    endtask

    task automatic test_load();
        mem_en = 1'b1; mem_wrt = 1'b0; alu_out = 32'h0000_0100;
        reg_wrt_en = 1'b1; result_sel = 2'b10; pc_next = 32'h0000_2004;
        lr = 32'hCAFE_0001; fl = 2'b01;
        @(negedge clk);
        checks++;
        if (stall_mem !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL load_c0: stall=%b req=%b want 1 0", stall_mem, mem_req);
        end
        checks++;
        if (wb_alu_out !== 32'h100 || wb_reg_wrt_en !== 1'b1 ||
            wb_result_sel !== 2'b10 || wb_pc_next !== 32'h2004 ||
            wb_lr !== 32'hCAFE_0001 || wb_fl !== 2'b01) begin
            errors++;
            $display("FAIL passthru: alu=%h we=%b sel=%b pc=%h lr=%h fl=%b",
                     wb_alu_out, wb_reg_wrt_en, wb_result_sel, wb_pc_next, wb_lr, wb_fl);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 ||
            stall_mem !== 1'b1) begin
            errors++;
            $display("FAIL load_c1: req=%b addr=%h we=%b stall=%b want 1 100 0 1",
                     mem_req, mem_addr, mem_we, stall_mem);
        end
        next_cycle();
        mem_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || stall_mem !== 1'b1) begin
            errors++;
            $display("FAIL load_c2: req=%b stall=%b want 1 1", mem_req, stall_mem);
        end
        next_cycle();
        mem_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || stall_mem !== 1'b1) begin
            errors++;
            $display("FAIL load_c3: req=%b stall=%b want 0 1", mem_req, stall_mem);
        end
        next_cycle();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        checks++;
        if (stall_mem !== 1'b1 || wb_mem_data !== 32'h0) begin
            errors++;
            $display("FAIL load_c4: stall=%b data=%h want 1 0", stall_mem, wb_mem_data);
        end
        next_cycle();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        checks++;
        if (stall_mem !== 1'b0 || wb_mem_data !== 32'hDEAD_BEEF ||
            mem_req !== 1'b0 || mem_addr !== 32'h100) begin
            errors++;
            $display("FAIL load_done: stall=%b data=%h req=%b addr=%h want 0 deadbeef 0 100",
                     stall_mem, wb_mem_data, mem_req, mem_addr);
        end
        next_cycle();
        mem_en = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_mem !== 1'b0 || wb_mem_data !== 32'h0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL load_idle: stall=%b data=%h req=%b want 0 0 0",
                     stall_mem, wb_mem_data, mem_req);
        end
        next_cycle();
    endtask

    task automatic test_store();
        mem_en = 1'b1; mem_wrt = 1'b1; alu_out = 32'h0000_0040;
        reg_2 = 32'h1234_5678; mem_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if (stall_mem !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL store_c0: stall=%b req=%b want 1 0", stall_mem, mem_req);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 ||
            mem_wdata !== 32'h1234_5678 || stall_mem !== 1'b1) begin
            errors++;
            $display("FAIL store_req: req=%b we=%b addr=%h wdata=%h stall=%b",
                     mem_req, mem_we, mem_addr, mem_wdata, stall_mem);
        end
        next_cycle();
        mem_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || stall_mem !== 1'b0 ||
            wb_mem_data !== 32'h0) begin
            errors++;
            $display("FAIL store_done: req=%b we=%b stall=%b data=%h want 0 0 0 0",
                     mem_req, mem_we, stall_mem, wb_mem_data);
        end
        next_cycle();
        mem_en = 1'b0; mem_wrt = 1'b0;
        next_cycle();
    endtask

    task automatic test_misalign();
        mem_en = 1'b1; mem_wrt = 1'b0; alu_out = 32'h0000_0102;
        @(negedge clk);
        checks++;
        if (err_mis !== 1'b1 || stall_mem !== 1'b0 || mem_req !== 1'b0 ||
            wb_mem_data !== 32'h0) begin
            errors++;
            $display("FAIL misalign: mis=%b stall=%b req=%b data=%h want 1 0 0 0",
                     err_mis, stall_mem, mem_req, wb_mem_data);
        end
        next_cycle();
        mem_en = 1'b0;
        @(negedge clk);
        checks++;
        if (err_mis !== 1'b0 || mem_req !== 1'b0 || stall_mem !== 1'b0) begin
            errors++;
            $display("FAIL misalign_after: mis=%b req=%b stall=%b want 0 0 0",
                     err_mis, mem_req, stall_mem);
        end
        next_cycle();
    endtask

    task automatic test_gnt_rvalid_same();
        mem_en = 1'b1; mem_wrt = 1'b0; alu_out = 32'h0000_0200;
        next_cycle();
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_AAAA;
        next_cycle();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_mem !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL gnt_rv_wait: stall=%b req=%b want 1 0", stall_mem, mem_req);
        end
        next_cycle();
        mem_rvalid = 1'b1; mem_rdata = 32'h5555_1234;
        next_cycle();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        checks++;
        if (wb_mem_data !== 32'h5555_1234 || stall_mem !== 1'b0) begin
            errors++;
            $display("FAIL gnt_rv_data: data=%h stall=%b want 55551234 0",
                     wb_mem_data, stall_mem);
        end
        next_cycle();
        mem_en = 1'b0;
        next_cycle();
    endtask

    task automatic test_timeout();
        int to_cycle;
        int req_bad;
        mem_en = 1'b1; mem_wrt = 1'b0; alu_out = 32'h0000_0300;
        next_cycle();
        to_cycle = -1;
        req_bad = 0;
        // REQ cycles counted from 1; counter reaches 8 in the ninth.
        for (int c = 1; c <= 12 && to_cycle < 0; c++) begin
            @(negedge clk);
            if (mem_req !== 1'b1 || stall_mem !== 1'b1) req_bad++;
            if (err_to === 1'b1) to_cycle = c;
            next_cycle();
        end
        checks++;
        if (to_cycle != 9) begin
            errors++;
            $display("FAIL timeout_cycle: pulse at REQ cycle %0d want 9", to_cycle);
        end
        checks++;
        if (req_bad != 0) begin
            errors++;
            $display("FAIL timeout_req: %0d cycles without req/stall want 0", req_bad);
        end
        @(negedge clk);
        checks++;
        if (err_to !== 1'b0 || mem_req !== 1'b0 || stall_mem !== 1'b0 ||
            wb_mem_data !== 32'h0) begin
            errors++;
            $display("FAIL timeout_done: to=%b req=%b stall=%b data=%h want 0 0 0 0",
                     err_to, mem_req, stall_mem, wb_mem_data);
        end
        next_cycle();
        mem_en = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset_in_wait();
        mem_en = 1'b1; mem_wrt = 1'b0; alu_out = 32'h0000_0400;
        next_cycle();
        mem_gnt = 1'b1;
        next_cycle();
        mem_gnt = 1'b0;
        rst_n = 1'b0; mem_en = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_mem !== 1'b1 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_pre: stall=%b req=%b want 1 0", stall_mem, mem_req);
        end
        next_cycle();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_0BAD;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || stall_mem !== 1'b0 || wb_mem_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_wait_idle: req=%b stall=%b data=%h want 0 0 0",
                     mem_req, stall_mem, wb_mem_data);
        end
        next_cycle();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || stall_mem !== 1'b0 || wb_mem_data !== 32'h0 ||
            mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rst_wait_late: req=%b stall=%b data=%h addr=%h want 0 0 0 0",
                     mem_req, stall_mem, wb_mem_data, mem_addr);
        end
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0; alu_out = 32'h0; reg_2 = 32'h0; mem_en = 1'b0;
        mem_wrt = 1'b0; reg_wrt_en = 1'b0; result_sel = 2'b00;
        pc_next = 32'h0; lr = 32'h0; fl = 2'b00;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #1;
        test_reset();
        test_load();
        test_store();
        test_misalign();
        test_gnt_rvalid_same();
        test_timeout();
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
